cache_line_arbiter: RTL



---
 rtl/cache_line_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cache_line_arbiter.sv
// Round-robin arbiter serialising icache/dcache line misses onto one 64-bit burst port.
// One 256-bit line moves at a time as a 4-beat burst; resp pulses for one cycle in DONE.
module cache_line_arbiter #(
  parameter int LINE_WIDTH  = 256,
  parameter int BEAT_WIDTH  = 64,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ic_address,
  input  logic                  ic_read,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  output logic                  ic_resp,
  input  logic [31:0]           dc_address,
  input  logic                  dc_read,
  input  logic                  dc_write,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  dc_resp,
  output logic [31:0]           bmem_address,
  output logic                  bmem_read,
  output logic                  bmem_write,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_resp
);

  // state | meaning
  // IDLE  | sample requests, grant one (round-robin on conflict)
  // READ  | burst read, one beat stored per bmem_resp
  // WRITE | burst write, beat k driven from the latched line
  // DONE  | one-cycle resp pulse to the granted requester
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam int BEATS     = LINE_WIDTH / BEAT_WIDTH;
  localparam int BEAT_BITS = $clog2(BEATS);
  localparam int SEL_BITS  = $clog2(LINE_WIDTH);
  localparam int LSB_BITS  = $clog2(BEAT_WIDTH);

  state_t                state, state_nxt;
  logic [BEAT_BITS-1:0]  beat;
  logic [SEL_BITS-1:0]   beat_base;
  logic                  grant_dc;
  logic                  last_grant_dc;
  logic [31:0]           addr_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic [LINE_WIDTH-1:0] ic_line_q;
  logic [LINE_WIDTH-1:0] dc_line_q;
  logic                  ic_req;
  logic                  dc_req;
  logic                  pick_dc;
  logic                  last_beat;
  logic [31:0]           req_addr;
  logic                  unused_addr_bits;

  assign ic_req    = ic_read;
  assign dc_req    = dc_read | dc_write;
  // On conflict the requester that did not win last time goes first.
  assign pick_dc   = dc_req && (!ic_req || !last_grant_dc);
  assign req_addr  = pick_dc ? dc_address : ic_address;
  assign last_beat = bmem_resp && (beat == BEAT_BITS'(BEATS - 1));
  assign beat_base = {beat, {LSB_BITS{1'b0}}};
  assign unused_addr_bits = ^req_addr[OFFSET_BITS-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ic_req || dc_req) state_nxt = (pick_dc && dc_write) ? WRITE : READ;
      READ:    if (last_beat) state_nxt = DONE;
      WRITE:   if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat          <= '0;
      grant_dc      <= 1'b0;
      last_grant_dc <= 1'b0;
      addr_q        <= '0;
      line_q        <= '0;
      ic_line_q     <= '0;
      dc_line_q     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (ic_req || dc_req) begin
            grant_dc      <= pick_dc;
            last_grant_dc <= pick_dc;
            addr_q        <= {req_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            beat          <= '0;
            if (pick_dc && dc_write) line_q <= dc_wdata;
          end
        end
        READ: begin
          if (bmem_resp) begin
            line_q[beat_base +: BEAT_WIDTH] <= bmem_rdata;
            beat <= beat + 1'b1;
            // Publish the whole line at once so rdata never shows a partial burst.
            if (last_beat) begin
              if (grant_dc) dc_line_q <= {bmem_rdata, line_q[LINE_WIDTH-BEAT_WIDTH-1:0]};
              else          ic_line_q <= {bmem_rdata, line_q[LINE_WIDTH-BEAT_WIDTH-1:0]};
            end
          end
        end
        WRITE: begin
          if (bmem_resp) beat <= beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bmem_address = addr_q;
  assign bmem_read    = (state == READ);
  assign bmem_write   = (state == WRITE);
  assign bmem_wdata   = (state == WRITE) ? line_q[beat_base +: BEAT_WIDTH] : '0;
  assign ic_resp      = (state == DONE) && !grant_dc;
  assign dc_resp      = (state == DONE) && grant_dc;
  assign ic_rdata     = ic_line_q;
  assign dc_rdata     = dc_line_q;

endmodule
